cve2_clock_gate_ctrl: RTL

Sequencer driving the enable of the core's clock gate cell. Runs on the free-running (ungated) clock and turns a core sleep request into a gate-off decision after an idle hysteresis window. Restores the gated clock on a wake event and holds it through a settle window before signalling the core. Sits between the core's sleep/idle status and the clock gate's en_i input.

---
 rtl/cve2_clock_gate_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/cve2_clock_gate_ctrl.sv
// Clock-gate enable sequencer: idle-hysteresis gate-off, settle-window wake-up.
// Optional gated-cycle statistics counter enabled by defining CVE2_CG_STATS_EN.
module cve2_clock_gate_ctrl #(
   parameter int unsigned IdleW      = 8,
   parameter int unsigned WakeCycles = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sleep_req_i,
   input  logic             core_idle_i,
   input  logic             wake_i,
   input  logic [IdleW-1:0] idle_cycles_i,
   input  logic             test_en_i,
   input  logic             stats_clr_i,
   output logic             clk_gate_en_o,
   output logic             sleep_ack_o,
   output logic             wake_done_o,
   output logic [31:0]      gated_cycles_o
);

   localparam int unsigned WakeEff = (WakeCycles == 0) ? 1 : WakeCycles;
   localparam int unsigned WakeW   = (WakeEff > 1) ? $clog2(WakeEff) : 1;
   localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeEff - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      GATED = 2'd2,
      WAKE  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
   logic [WakeW-1:0]   wake_cnt_q, wake_cnt_d;
   logic               wake_done_q, wake_done_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         idle_cnt_q  <= '0;
         wake_cnt_q  <= '0;
         wake_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         wake_cnt_q  <= wake_cnt_d;
         wake_done_q <= wake_done_d;
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      wake_cnt_d = '0;
      unique case (state_q)
         RUN: begin
            if (sleep_req_i && !wake_i) state_d = DRAIN;
         end
         DRAIN: begin
            // Abort beats idleness; a busy cycle leaves the cleared counter.
            if (wake_i || !sleep_req_i) begin
               state_d = RUN;
            end else if (core_idle_i) begin
               if (idle_cnt_q >= idle_cycles_i) begin
                  state_d = GATED;
               end else if (idle_cnt_q != '1) begin
                  idle_cnt_d = idle_cnt_q + IdleW'(1);
               end else begin
                  idle_cnt_d = idle_cnt_q;
               end
            end
         end
         GATED: begin
            if (wake_i) state_d = WAKE;
         end
         WAKE: begin
            if (wake_cnt_q == WakeLast) state_d = RUN;
            else                        wake_cnt_d = wake_cnt_q + WakeW'(1);
         end
         default: state_d = RUN;
      endcase
      wake_done_d = (state_q == WAKE) && (state_d == RUN);
   end

   always_comb begin
      clk_gate_en_o = (state_q != GATED) | test_en_i;
      sleep_ack_o   = (state_q == GATED);
      wake_done_o   = wake_done_q;
   end

`ifdef CVE2_CG_STATS_EN
   logic [31:0] gated_cnt_q, gated_cnt_d;

   always_comb begin
      gated_cnt_d = gated_cnt_q;
      if (stats_clr_i)                                        gated_cnt_d = '0;
      else if (state_q == GATED && gated_cnt_q != 32'hFFFF_FFFF) gated_cnt_d = gated_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) gated_cnt_q <= '0;
      else       gated_cnt_q <= gated_cnt_d;
   end

   assign gated_cycles_o = gated_cnt_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr_i;
   assign gated_cycles_o   = '0;
`endif

endmodule
